// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared types and constants for the drum mesh column engine
package drum_pkg;

  localparam int DW = 18;
  localparam int ACC_W = 36;

  localparam int RHO_SHIFT  = 4;
  localparam int PREV_SHIFT = 12;
  localparam int DAMP_SHIFT = 13;

  typedef logic signed [DW-1:0]    node_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME0,
    ST_PRIME1,
    ST_SWEEP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/drum_column_engine_node_update.sv
// rtl/drum_column_engine_node_update.sv - damped finite-difference update for one node
module node_update
  import drum_pkg::*;
(
  input  node_t l,
  input  node_t r,
  input  node_t up_row,
  input  node_t down_row,
  input  node_t u,
  input  node_t u_prev,
  output node_t next
);

  acc_t lap;
  acc_t rho;
  acc_t t;
  acc_t n;

  // Everything is widened before summing so only the final truncation can wrap.
  assign lap = acc_t'(l) + acc_t'(r) + acc_t'(up_row) + acc_t'(down_row)
             - (acc_t'(u) <<< 2);
  assign rho = lap >>> RHO_SHIFT;
  assign t   = rho + (acc_t'(u) <<< 1) - acc_t'(u_prev)
             + (acc_t'(u_prev) >>> PREV_SHIFT);
  assign n   = t - (t >>> DAMP_SHIFT);

  assign next = node_t'(n);

endmodule

// File: rtl/drum_column_engine.sv
// rtl/drum_column_engine.sv - one drum mesh column: u/u_prev RAMs and a row-serial sweep
module drum_column_engine
  import drum_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int AW   = 5,
  parameter int DW   = drum_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_we,
  input  logic [AW-1:0] init_row,
  input  logic [DW-1:0] init_u,
  input  logic          step_start,
  input  logic [DW-1:0] left_u,
  input  logic [DW-1:0] right_u,
  output logic [AW-1:0] cur_row,
  output logic [DW-1:0] center_u,
  output logic          busy,
  output logic          step_done,
  output logic [DW-1:0] mid_u
);

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [AW-1:0] MID_ROW  = AW'(ROWS / 2);
  localparam logic [AW:0]   ROWS_X   = (AW + 1)'(ROWS);

  state_t state, state_nx;

  node_t u_mem [ROWS];
  node_t p_mem [ROWS];

  node_t u_rdata, p_rdata;
  node_t center_q, down_q, mid_q;
  node_t up_val, next_val;
  logic [AW-1:0] row_q;

  logic          u_re, p_re;
  logic [AW-1:0] u_raddr, p_raddr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  node_t         u_wdata, p_wdata;
  logic [AW:0]   row_ext;
  logic          sweeping;

  assign row_ext  = {1'b0, row_q};
  assign sweeping = (state == ST_SWEEP);

  always_comb begin
    state_nx = state;
    u_re     = 1'b0;
    u_raddr  = '0;
    p_re     = 1'b0;
    p_raddr  = '0;
    case (state)
      ST_IDLE:   if (step_start) state_nx = ST_PRIME0;
      ST_PRIME0: begin
        u_re     = 1'b1;
        state_nx = ST_PRIME1;
      end
      ST_PRIME1: begin
        u_re     = 1'b1;
        u_raddr  = AW'(1);
        p_re     = 1'b1;
        state_nx = ST_SWEEP;
      end
      ST_SWEEP: begin
        // Reads run ahead of the write row; past the end they are simply not issued.
        if (row_ext + (AW + 1)'(2) < ROWS_X) begin
          u_re    = 1'b1;
          u_raddr = row_q + AW'(2);
        end
        if (row_ext + (AW + 1)'(1) < ROWS_X) begin
          p_re    = 1'b1;
          p_raddr = row_q + AW'(1);
        end
        if (row_q == LAST_ROW) state_nx = ST_DONE;
      end
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  assign mem_we    = sweeping || (state == ST_IDLE && init_we);
  assign mem_waddr = sweeping ? row_q    : init_row;
  assign u_wdata   = sweeping ? next_val : node_t'(init_u);
  assign p_wdata   = sweeping ? center_q : node_t'(init_u);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      u_mem[mem_waddr] <= u_wdata;
      p_mem[mem_waddr] <= p_wdata;
    end
    if (u_re) u_rdata <= u_mem[u_raddr];
    if (p_re) p_rdata <= p_mem[p_raddr];
  end

  assign up_val = (row_q == LAST_ROW) ? '0 : u_rdata;

  node_update u_node (
    .l        (node_t'(left_u)),
    .r        (node_t'(right_u)),
    .up_row   (up_val),
    .down_row (down_q),
    .u        (center_q),
    .u_prev   (p_rdata),
    .next     (next_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      center_q <= '0;
      down_q   <= '0;
      mid_q    <= '0;
    end else if (state == ST_PRIME1) begin
      row_q    <= '0;
      center_q <= u_rdata;
      down_q   <= '0;
    end else if (sweeping) begin
      row_q    <= (row_q == LAST_ROW) ? '0 : row_q + AW'(1);
      center_q <= u_rdata;
      down_q   <= center_q;
      if (row_q == MID_ROW) mid_q <= next_val;
    end
  end

  assign cur_row   = row_q;
  assign center_u  = center_q;
  assign mid_u     = mid_q;
  assign busy      = (state == ST_PRIME0) || (state == ST_PRIME1) || sweeping;
  assign step_done = (state == ST_DONE);

endmodule

// File: tb/tb_drum_column_engine.sv
// tb/tb_drum_column_engine.sv - scoreboard bench for drum_column_engine
module tb_drum_column_engine;

  localparam int ROWS = 30;
  localparam int AW   = 5;
  localparam int DW   = 18;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 init_we = 1'b0;
  logic [AW-1:0]        init_row = '0;
  logic [DW-1:0]        init_u = '0;
  logic                 step_start = 1'b0;
  logic [DW-1:0]        left_u = '0;
  logic [DW-1:0]        right_u = '0;
  logic [AW-1:0]        cur_row;
  logic signed [DW-1:0] center_u;
  logic                 busy;
  logic                 step_done;
  logic signed [DW-1:0] mid_u;

  drum_column_engine #(.ROWS(ROWS), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_we    (init_we),
    .init_row   (init_row),
    .init_u     (init_u),
    .step_start (step_start),
    .left_u     (left_u),
    .right_u    (right_u),
    .cur_row    (cur_row),
    .center_u   (center_u),
    .busy       (busy),
    .step_done  (step_done),
    .mid_u      (mid_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] mid;
  } done_t;

  done_t                done_q[$];
  logic signed [DW-1:0] cen_q[$];
  logic signed [DW-1:0] img [ROWS];

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: rows appear from the third busy cycle on; step_done closes a step.
  always @(negedge clk) begin
    if (busy) begin
      if (busy_cnt >= 2) begin
        if (cen_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_row: got row %0d expected no sweep", cur_row);
        end else begin
          logic signed [DW-1:0] e;
          e = cen_q.pop_front();
          check("cur_row", {1'b0, cur_row}, busy_cnt - 2);
          check("center_u", center_u, e);
        end
      end
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
    if (step_done) begin
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_step_done: got pulse expected none at cycle %0d", cyc);
      end else begin
        done_t d;
        d = done_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("mid_u", mid_u, d.mid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void clear_img();
    foreach (img[i]) img[i] = '0;
  endfunction

  function automatic void set_impulse();
    clear_img();
    img[15] = 18'sd4096;
  endfunction

  function automatic void set_res1();
    clear_img();
    img[14] = 18'sd256;
    img[15] = 18'sd3073;
    img[16] = 18'sd256;
  endfunction

  task automatic load_img();
    for (int r = 0; r < ROWS; r++) begin
      init_we  = 1'b1;
      init_row = AW'(r);
      init_u   = img[r];
      tick();
    end
    init_we = 1'b0;
  endtask

  task automatic start_step(input logic signed [DW-1:0] mid_exp);
    done_t d;
    for (int r = 0; r < ROWS; r++) cen_q.push_back(img[r]);
    d.cyc = cyc + ROWS + 3;
    d.mid = mid_exp;
    done_q.push_back(d);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && done_q.size() != 0; i++) tick();
    tests++;
    if (done_q.size() != 0) begin
      fails++;
      $display("FAIL step_timeout: got %0d pending steps expected 0", done_q.size());
      done_q.delete();
      cen_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic do_step(input logic signed [DW-1:0] mid_exp);
    start_step(mid_exp);
    wait_done();
  endtask

  initial begin
    bit found;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_busy", busy, 0);
    check("reset_step_done", step_done, 0);
    check("reset_mid_u", mid_u, 0);
    check("reset_cur_row", {1'b0, cur_row}, 0);
    check("reset_center_u", center_u, 0);

    // All-zero column stays zero.
    clear_img();
    load_img();
    do_step(18'sd0);

    // Impulse at the middle row, then a second step to read back the result.
    set_impulse();
    load_img();
    do_step(18'sd3073);
    set_res1();
    do_step(18'sd1314);

    // Impulse at row 0: no wrap into the last row.
    clear_img();
    img[0] = 18'sd4096;
    load_img();
    do_step(18'sd0);
    clear_img();
    img[0] = 18'sd3073;
    img[1] = 18'sd256;
    do_step(18'sd0);

    // Constant left neighbour drive.
    clear_img();
    load_img();
    left_u = 18'd4096;
    do_step(18'sd256);
    left_u = '0;
    foreach (img[i]) img[i] = 18'sd256;
    do_step(18'sd480);

    // Init write in the same cycle as step_start is used by that sweep.
    clear_img();
    load_img();
    set_impulse();
    init_we  = 1'b1;
    init_row = AW'(15);
    init_u   = 18'd4096;
    start_step(18'sd3073);
    init_we = 1'b0;
    wait_done();
    set_res1();
    do_step(18'sd1314);

    // step_start and init_we while busy are ignored.
    set_impulse();
    load_img();
    start_step(18'sd3073);
    repeat (5) tick();
    step_start = 1'b1;
    init_we    = 1'b1;
    init_row   = AW'(3);
    init_u     = 18'd777;
    tick();
    step_start = 1'b0;
    init_we    = 1'b0;
    wait_done();
    repeat (10) tick();
    set_res1();
    do_step(18'sd1314);

    // Reset in the middle of a sweep.
    set_impulse();
    load_img();
    start_step(18'sd3073);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (busy && cur_row == AW'(10)) found = 1'b1;
    end
    check("reach_row10", {31'd0, found}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cen_q.delete();
    done_q.delete();
    check("midreset_busy", busy, 0);
    check("midreset_step_done", step_done, 0);
    check("midreset_mid_u", mid_u, 0);
    check("midreset_cur_row", {1'b0, cur_row}, 0);
    repeat (40) tick();
    set_impulse();
    load_img();
    do_step(18'sd3073);
    set_res1();
    do_step(18'sd1314);

    check("queues_empty", cen_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
